// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational adder between
// the PC+4 requester (0) and the branch-target requester (1).
//
// state  | meaning
// IDLE   | no operation in progress, arbitrating req_in
// SETTLE | operands launched, counting down adder settle time
// DONE   | sum captured, one-cycle done pulse to the granted requester
module adder_share_arbiter #(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 3
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic [1:0]       req_in,
   input  logic [WIDTH-1:0] a0_in,
   input  logic [WIDTH-1:0] b0_in,
   input  logic [WIDTH-1:0] a1_in,
   input  logic [WIDTH-1:0] b1_in,
   output logic [WIDTH-1:0] add_a_out,
   output logic [WIDTH-1:0] add_b_out,
   input  logic [WIDTH-1:0] add_result_in,
   output logic [1:0]       gnt_out,
   output logic [1:0]       done_out,
   output logic [WIDTH-1:0] result_out,
   output logic             busy_out
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   // A zero settle time still needs one edge for the adder output to be sampled.
   localparam int SETTLE_EFF = (SETTLE_CYCLES < 1)  ? 1  :
                               (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_EFF - 1);

   logic [1:0]       state_q,  state_d;
   logic [3:0]       cnt_q,    cnt_d;
   logic             ptr_q,    ptr_d;
   logic [1:0]       gnt_q,    gnt_d;
   logic [1:0]       done_q,   done_d;
   logic [WIDTH-1:0] add_a_q,  add_a_d;
   logic [WIDTH-1:0] add_b_q,  add_b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             winner;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      gnt_d    = gnt_q;
      done_d   = done_q;
      add_a_d  = add_a_q;
      add_b_d  = add_b_q;
      result_d = result_q;
      winner   = (req_in == 2'b11) ? ptr_q : req_in[1];

      case (state_q)
         ST_IDLE: begin
            if (req_in != 2'b00) begin
               add_a_d = winner ? a1_in : a0_in;
               add_b_d = winner ? b1_in : b0_in;
               gnt_d   = winner ? 2'b10 : 2'b01;
               cnt_d   = CNT_LOAD;
               ptr_d   = ~winner;
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               result_d = add_result_in;
               done_d   = gnt_q;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            done_d  = 2'b00;
            gnt_d   = 2'b00;
            state_d = ST_IDLE;
         end
         default: begin
            done_d  = 2'b00;
            gnt_d   = 2'b00;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         ptr_q    <= 1'b0;
         gnt_q    <= 2'b00;
         done_q   <= 2'b00;
         add_a_q  <= '0;
         add_b_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         add_a_q  <= add_a_d;
         add_b_q  <= add_b_d;
         result_q <= result_d;
      end
   end

   assign add_a_out  = add_a_q;
   assign add_b_out  = add_b_q;
   assign gnt_out    = gnt_q;
   assign done_out   = done_q;
   assign result_out = result_q;
   assign busy_out   = (state_q == ST_SETTLE) || (state_q == ST_DONE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: models the shared adder and checks grants,
// sums and timing against a round-robin reference kept here.
module tb_adder_share_arbiter;

   localparam int SC = 3;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req;
   logic [31:0] a0, b0, a1, b1;
   logic [31:0] add_a_out, add_b_out, add_result_in, result_out;
   logic [1:0]  gnt_out, done_out;
   logic        busy_out;

   int n_checks = 0;
   int n_fail   = 0;
   int model_ptr = 0;

   adder_share_arbiter #(.WIDTH(32), .SETTLE_CYCLES(SC)) dut (
      .clk_in        (clk),
      .rst_n_in      (rst_n),
      .req_in        (req),
      .a0_in         (a0),
      .b0_in         (b0),
      .a1_in         (a1),
      .b1_in         (b1),
      .add_a_out     (add_a_out),
      .add_b_out     (add_b_out),
      .add_result_in (add_result_in),
      .gnt_out       (gnt_out),
      .done_out      (done_out),
      .result_out    (result_out),
      .busy_out      (busy_out)
   );

   assign add_result_in = add_a_out + add_b_out;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic apply_reset();
      rst_n = 1'b0;
      req = 2'b00;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_ptr = 0;
   endtask

   // Collects what happened during one operation; the grant edge is the next posedge.
   task automatic observe_op(output logic [1:0] g, output logic [31:0] res,
                             output logic [1:0] d, output int lat,
                             output logic [1:0] after, output logic busy_after);
      @(posedge clk); #1;
      g   = gnt_out;
      lat = 0;
      while (lat < 40 && done_out == 2'b00) begin
         @(posedge clk); #1;
         lat++;
      end
      d   = done_out;
      res = result_out;
      @(posedge clk); #1;
      after      = done_out | gnt_out;
      busy_after = busy_out;
   endtask

   task automatic test_reset();
      logic [1:0] g, d, after;
      logic [31:0] res;
      logic busy_after;
      int lat;
      rst_n = 1'b0;
      req = 2'b11;
      a0 = 32'h11; b0 = 32'h22; a1 = 32'h33; b1 = 32'h44;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({add_a_out, add_b_out, result_out} !== 96'd0) begin
         n_fail++;
         $display("FAIL reset_data: got a=%h b=%h r=%h expected 0", add_a_out, add_b_out, result_out);
      end
      n_checks++;
      if ({gnt_out, done_out, busy_out} !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got gnt=%b done=%b busy=%b expected 0", gnt_out, done_out, busy_out);
      end
      rst_n = 1'b1;
      model_ptr = 0;
      observe_op(g, res, d, lat, after, busy_after);
      n_checks++;
      if (g !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_first_grant: got %b expected 01", g);
      end
      n_checks++;
      if (res !== 32'h33) begin
         n_fail++;
         $display("FAIL reset_first_sum: got %h expected 00000033", res);
      end
      req = 2'b00;
   endtask

   task automatic test_single();
      int lat;
      apply_reset();
      a0 = 32'h0040_0000; b0 = 32'd4; req = 2'b01;
      @(posedge clk); #1;
      n_checks++;
      if (gnt_out !== 2'b01 || busy_out !== 1'b1) begin
         n_fail++;
         $display("FAIL single_grant: got gnt=%b busy=%b expected 01/1", gnt_out, busy_out);
      end
      lat = 0;
      while (lat < 40 && done_out == 2'b00) begin
         n_checks++;
         if (add_a_out !== 32'h0040_0000 || add_b_out !== 32'd4) begin
            n_fail++;
            $display("FAIL single_operands: got a=%h b=%h expected 00400000/4", add_a_out, add_b_out);
         end
         @(posedge clk); #1;
         lat++;
      end
      n_checks++;
      if (lat !== SC) begin
         n_fail++;
         $display("FAIL single_latency: got %0d expected %0d", lat, SC);
      end
      n_checks++;
      if (done_out !== 2'b01 || result_out !== 32'h0040_0004) begin
         n_fail++;
         $display("FAIL single_done: got done=%b r=%h expected 01/00400004", done_out, result_out);
      end
      req = 2'b00;
      @(posedge clk); #1;
      n_checks++;
      if (done_out !== 2'b00 || gnt_out !== 2'b00 || busy_out !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle: got done=%b gnt=%b busy=%b expected 0", done_out, gnt_out, busy_out);
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (result_out !== 32'h0040_0004 || add_a_out !== 32'h0040_0000 || gnt_out !== 2'b00) begin
         n_fail++;
         $display("FAIL single_hold: got r=%h a=%h gnt=%b expected 00400004/00400000/00", result_out, add_a_out, gnt_out);
      end
   endtask

   task automatic test_fairness();
      logic [1:0] g, d, after;
      logic [31:0] res;
      logic busy_after;
      int lat;
      apply_reset();
      a0 = 32'h0000_0100; b0 = 32'd4;
      a1 = 32'h0000_1000; b1 = 32'hFFFF_FFF0;
      req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         observe_op(g, res, d, lat, after, busy_after);
         n_checks++;
         if (g !== ((i % 2 == 0) ? 2'b01 : 2'b10) || d !== g) begin
            n_fail++;
            $display("FAIL fair_grant[%0d]: got gnt=%b done=%b expected alternating from 01", i, g, d);
         end
         n_checks++;
         if (res !== ((i % 2 == 0) ? 32'h0000_0104 : 32'h0000_0FF0)) begin
            n_fail++;
            $display("FAIL fair_sum[%0d]: got %h", i, res);
         end
      end
      req = 2'b10; a1 = 32'hFFFF_FFFF; b1 = 32'd1;
      observe_op(g, res, d, lat, after, busy_after);
      n_checks++;
      if (res !== 32'd0 || d !== 2'b10) begin
         n_fail++;
         $display("FAIL wrap: got r=%h done=%b expected 00000000/10", res, d);
      end
      req = 2'b00;
   endtask

   task automatic test_operand_change();
      int lat;
      apply_reset();
      a0 = 32'd8; b0 = 32'd8; req = 2'b01;
      @(posedge clk);
      @(posedge clk); #1;
      a0 = 32'd100;
      lat = 1;
      while (lat < 40 && done_out == 2'b00) begin
         @(posedge clk); #1;
         lat++;
      end
      n_checks++;
      if (result_out !== 32'd16 || done_out !== 2'b01) begin
         n_fail++;
         $display("FAIL operand_change: got r=%0d done=%b expected 16/01", result_out, done_out);
      end
      req = 2'b00;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_settle();
      logic [1:0] g, d, after;
      logic [31:0] res;
      logic busy_after;
      logic [1:0] done_seen;
      int lat;
      apply_reset();
      a0 = 32'd1; b0 = 32'd2; a1 = 32'd5; b1 = 32'd6;
      req = 2'b01;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({gnt_out, done_out, busy_out} !== 5'd0 || add_a_out !== 32'd0) begin
         n_fail++;
         $display("FAIL midreset_clear: got gnt=%b done=%b busy=%b a=%h expected 0", gnt_out, done_out, busy_out, add_a_out);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      req = 2'b00;
      done_seen = 2'b00;
      for (int i = 0; i < SC + 3; i++) begin
         @(posedge clk); #1;
         done_seen = done_seen | done_out;
      end
      n_checks++;
      if (done_seen !== 2'b00) begin
         n_fail++;
         $display("FAIL midreset_nodone: got done=%b expected 00", done_seen);
      end
      model_ptr = 0;
      req = 2'b11;
      observe_op(g, res, d, lat, after, busy_after);
      n_checks++;
      if (g !== 2'b01 || res !== 32'd3) begin
         n_fail++;
         $display("FAIL midreset_ptr: got gnt=%b r=%h expected 01/3", g, res);
      end
      req = 2'b00;
   endtask

   task automatic test_random();
      logic [1:0] g, d, after;
      logic [31:0] res, exp_sum;
      logic busy_after;
      logic [1:0] exp_g;
      int lat, win;
      apply_reset();
      for (int i = 0; i < 30; i++) begin
         req = 2'($urandom_range(1, 3));
         a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
         win = (req == 2'b11) ? model_ptr : ((req == 2'b10) ? 1 : 0);
         model_ptr = 1 - win;
         exp_g = (win == 1) ? 2'b10 : 2'b01;
         exp_sum = (win == 1) ? 32'(a1 + b1) : 32'(a0 + b0);
         observe_op(g, res, d, lat, after, busy_after);
         n_checks++;
         if (g !== exp_g || d !== exp_g || res !== exp_sum) begin
            n_fail++;
            $display("FAIL rand_op[%0d]: got gnt=%b done=%b r=%h expected %b/%b/%h", i, g, d, res, exp_g, exp_g, exp_sum);
         end
         n_checks++;
         if (lat !== SC || after !== 2'b00 || busy_after !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_timing[%0d]: got lat=%0d after=%b busy=%b expected %0d/00/0", i, lat, after, busy_after, SC);
         end
         if ($urandom_range(0, 3) == 0) begin
            req = 2'b00;
            repeat (2) @(posedge clk);
            #1;
            n_checks++;
            if (gnt_out !== 2'b00 || busy_out !== 1'b0) begin
               n_fail++;
               $display("FAIL rand_idle[%0d]: got gnt=%b busy=%b expected 00/0", i, gnt_out, busy_out);
            end
         end
      end
      req = 2'b00;
   endtask

   initial begin
      rst_n = 1'b0;
      req = 2'b00;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      test_reset();
      test_single();
      test_fairness();
      test_operand_change();
      test_reset_mid_settle();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one combinational 32-bit adder (the branch/PC adder) between two requesters: requester 0 = PC+4 increment, requester 1 = branch target computation.
- Grants the adder round-robin and drives its operands from registers.
- Waits a fixed number of settle cycles to cover the adder's propagation delay, then captures the sum and returns it with a one-cycle done pulse.
- Sits between the fetch/branch control logic and the shared adder instance.

Parameters:
- WIDTH, 32, operand/result width.
- SETTLE_CYCLES, 3, clock cycles between operand launch and result capture. Legal range is 1..15; a value of 0 is treated as 1.

Ports:
- clk_in  input  1  single clock, rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- req_in  input  2  per-requester request level; bit i = requester i.
- a0_in  input  WIDTH  requester 0 operand A.
- b0_in  input  WIDTH  requester 0 operand B.
- a1_in  input  WIDTH  requester 1 operand A.
- b1_in  input  WIDTH  requester 1 operand B.
- add_a_out  output  WIDTH  registered operand A to the shared adder.
- add_b_out  output  WIDTH  registered operand B to the shared adder.
- add_result_in  input  WIDTH  sum returned from the shared adder.
- gnt_out  output  2  one-hot grant; zero when idle.
- done_out  output  2  one-cycle completion pulse to the granted requester.
- result_out  output  WIDTH  captured sum; valid while done_out is nonzero, held afterwards.
- busy_out  output  1  high in SETTLE and DONE states.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE.
  - add_a_out, add_b_out, result_out = 0.
  - gnt_out, done_out = 2'b00.
  - busy_out = 0.
  - Round-robin pointer = 0, so requester 0 wins the first tie.
  - Settle counter = 0.
- States:
  - IDLE: no operation in progress.
  - SETTLE: operands launched, waiting for the adder to settle.
  - DONE: result captured, done pulse driven.
- IDLE:
  - If req_in == 0, stay in IDLE.
  - If exactly one bit is set, that requester wins.
  - If both bits are set, the requester named by the pointer wins.
  - On the grant edge:
    - latch the winner's operands into add_a_out/add_b_out;
    - set gnt_out = one-hot of the winner;
    - load counter = SETTLE_CYCLES-1;
    - pointer = other requester;
    - go to SETTLE.
- SETTLE:
  - Operands are held constant.
  - If counter != 0: decrement counter.
  - If counter == 0: result_out <= add_result_in, done_out <= gnt_out, go to DONE.
- DONE:
  - Lasts exactly one cycle.
  - On the next edge: done_out = 0, gnt_out = 0, go to IDLE.
  - req_in is ignored in this state.
- Latency: request sampled at edge E0 → result captured at edge E0+SETTLE_CYCLES → done_out high for the cycle following that edge.
- Throughput: at most one operation per SETTLE_CYCLES+2 cycles.
- Requester protocol:
  - Hold req and operands stable until done is seen.
  - Deassert req at the edge that samples done.
  - Operand changes after the grant edge have no effect.
  - If req drops mid-operation (protocol violation), the operation still completes and done still pulses.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1…
- Arithmetic: no carry or overflow output; result_out is the adder's modulo-2^WIDTH sum, taken unmodified.
- Reset mid-operation: everything returns to reset values immediately. No done pulse is issued and the pending operation is dropped.
- add_a_out/add_b_out retain their last values when idle. Only reset clears them.

Test Plan:
- Reset: hold rst_n_in=0 with req_in=2'b11 → all outputs 0, busy_out=0; after release, first grant is requester 0.
- Single request, SETTLE_CYCLES=3: req_in=2'b01, a0=32'h0040_0000, b0=4 at edge E0 → gnt_out=01 from E0. result_out=32'h0040_0004 and done_out=01 for exactly one cycle after E0+3. Back to IDLE after E0+4.
- Contention/fairness: req_in=2'b11 held for four operations, a1=32'h0000_1000, b1=32'hFFFF_FFF0 → grants 0,1,0,1. Requester 1's result = 32'h0000_0FF0.
- Wrap-around: a1=32'hFFFF_FFFF, b1=1 → result_out=0, done_out=10.
- Operand change after grant: a0 changed from 8 to 100 one cycle after grant, b0=8 → result_out=16.
- Reset mid-SETTLE: assert rst_n_in one cycle after grant → done_out never pulses, state IDLE, pointer back to 0.
